mprj_io_serial_loader: RTL and testbench

- Wishbone master plus serial sequencer that transfers the per-pad IO configuration words out of the project-control register file into the GPIO pad shift chain.
- On `start`, reads IO_PADS config registers over Wishbone and shifts CFG_BITS of each word out on serial_clock/serial_data_out.
- When the whole chain is filled, pulses serial_load so the pads latch their new configuration.
- Sits between the management SoC Wishbone bus and the pad chain, next to the control register block.

---
 rtl/mprj_io_serial_loader_if.sv | 21 ++
 rtl/mprj_io_serial_loader.sv | 171 +++++++++++++++++
 tb/tb_mprj_io_serial_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mprj_io_serial_loader_if.sv
// Wishbone read-master bundle between the serial loader and the SoC bus.
// A read is requested while cyc&stb are high and completes in the cycle ack is high; the master keeps adr/sel/stb steady until then.
interface mprj_io_serial_loader_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/mprj_io_serial_loader.sv
// Reads the per-pad IO config words over Wishbone and shifts them MSB first
// into the GPIO pad chain, highest pad first, then pulses serial_load.
module mprj_io_serial_loader #(
   parameter logic [31:0] BASE_ADR    = 32'h2300_0000,
   parameter int          IO_PADS     = 32,
   parameter int          CFG_BITS    = 13,
   parameter int          CLK_DIV     = 2,
   parameter int          ACK_TIMEOUT = 255
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       serial_clock,
   output logic       serial_data_out,
   output logic       serial_load,
   output logic [2:0] dbg_state,
   mprj_io_serial_loader_if.master wbm
);

   localparam int IDX_W = (IO_PADS > 1) ? $clog2(IO_PADS) : 1;
   localparam int BIT_W = $clog2(CFG_BITS + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(IO_PADS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, READ, SHIFT_LO, SHIFT_HI, NEXT, LOAD, FIN
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [CFG_BITS-1:0] sh_q, sh_d;
   logic                acked_q, acked_d;
   logic                err_q, err_d;
   logic                req;

   // Only the low CFG_BITS of each word reach the chain.
   logic unused_dat;
   assign unused_dat = ^wbm.wbm_dat_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         idx_q   <= IDX_MAX;
         bit_q   <= '0;
         div_q   <= '0;
         to_q    <= '0;
         sh_q    <= '0;
         acked_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         to_q    <= to_d;
         sh_q    <= sh_d;
         acked_q <= acked_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bit_d   = bit_q;
      div_d   = div_q;
      to_d    = to_q;
      sh_d    = sh_q;
      acked_d = acked_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               idx_d   = IDX_MAX;
               err_d   = 1'b0;
               acked_d = 1'b0;
               to_d    = '0;
            end
         end
         READ: begin
            // acked_q marks the release cycle after the ack has been taken.
            if (acked_q) begin
               state_d = SHIFT_LO;
               acked_d = 1'b0;
               bit_d   = BIT_W'(CFG_BITS);
               div_d   = '0;
            end else if (wbm.wbm_ack_i) begin
               sh_d    = wbm.wbm_dat_i[CFG_BITS-1:0];
               acked_d = 1'b1;
            end else if (to_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         SHIFT_LO: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = SHIFT_HI;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               bit_d = bit_q - 1'b1;
               if (bit_q == BIT_W'(1)) begin
                  state_d = NEXT;
               end else begin
                  sh_d    = sh_q << 1;
                  state_d = SHIFT_LO;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         NEXT: begin
            if (idx_q == '0) begin
               state_d = LOAD;
               div_d   = '0;
            end else begin
               idx_d   = idx_q - 1'b1;
               to_d    = '0;
               acked_d = 1'b0;
               state_d = READ;
            end
         end
         LOAD: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = FIN;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req             = (state_q == READ) && !acked_q;
      busy            = (state_q != IDLE);
      done            = (state_q == FIN);
      err             = err_q;
      serial_clock    = (state_q == SHIFT_HI);
      serial_data_out = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && sh_q[CFG_BITS-1];
      serial_load     = (state_q == LOAD);
      wbm.wbm_cyc_o   = req;
      wbm.wbm_stb_o   = req;
      wbm.wbm_we_o    = 1'b0;
      wbm.wbm_sel_o   = req ? 4'hF : 4'h0;
      wbm.wbm_adr_o   = req ? (BASE_ADR + (32'(idx_q) << 2)) : 32'h0;
      dbg_state       = state_q;
   end

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Scoreboard bench for mprj_io_serial_loader: directed transfers, a latency-
// programmable Wishbone slave, and a pad-chain model fed by serial_clock.
module tb_mprj_io_serial_loader;
   localparam logic [31:0] BASE = 32'h2300_0000;
   localparam int PADS = 4;
   localparam int CB   = 13;

   logic clk = 1'b0;
   logic rst, start;
   logic busy, done, err, sclk, sdo, sload;
   logic [2:0] dbg;

   mprj_io_serial_loader_if wbm ();

   mprj_io_serial_loader #(
      .BASE_ADR(BASE), .IO_PADS(PADS), .CFG_BITS(CB), .CLK_DIV(2), .ACK_TIMEOUT(255)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .busy(busy), .done(done),
      .err(err), .serial_clock(sclk), .serial_data_out(sdo), .serial_load(sload),
      .dbg_state(dbg), .wbm(wbm)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic unexpected(input string nm);
      total_cnt++;
      $display("FAIL %s: got event expected none", nm);
   endtask

   function automatic logic [31:0] mk_done(input logic e, input int l, input int ed, input int d);
      return {3'b0, e, 4'(l), 8'(ed), 16'(d)};
   endfunction

   // Wishbone slave: acks after lat cycles of strobe, never for pad nack_pad
   logic [31:0] regs [PADS];
   int lat = 1;
   int nack_pad = -1;
   int scnt = 0;
   int pad_sel;

   always_comb pad_sel = int'(((wbm.wbm_adr_o - BASE) >> 2) & 32'h3);
   assign wbm.wbm_dat_i = wbm.wbm_ack_i ? regs[pad_sel] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (rst || !(wbm.wbm_cyc_o && wbm.wbm_stb_o) || wbm.wbm_ack_i) begin
         wbm.wbm_ack_i <= 1'b0;
         scnt <= 0;
      end else begin
         if (scnt == lat - 1 && pad_sel != nack_pad) wbm.wbm_ack_i <= 1'b1;
         scnt <= scnt + 1;
      end
   end

   // Scoreboard queues
   logic [31:0] exp_adr_q[$];
   logic [15:0] exp_stb_q[$];
   logic [12:0] exp_pad_q[$];
   logic [31:0] exp_done_q[$];

   // Monitor state
   logic [PADS*CB-1:0] chain;
   logic prev_sclk, prev_load, prev_stb, hi_bit, after_done, mstb;
   logic [31:0] stb_adr;
   int edge_cnt, dur_cnt, load_cyc, stb_len;
   int ack_cnt = 0;
   int done_cnt = 0;
   int total_loads = 0;

   always_comb mstb = wbm.wbm_cyc_o && wbm.wbm_stb_o;

   always @(negedge clk) begin
      if (rst) begin
         chain = '0; prev_sclk = 0; prev_load = 0; prev_stb = 0; hi_bit = 0;
         after_done = 0; edge_cnt = 0; dur_cnt = 0; load_cyc = 0; stb_len = 0;
      end else begin
         if (after_done) begin
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("done_width", 32'(done), 32'd0);
            after_done = 0;
         end
         if (busy) dur_cnt++;
         if (sclk && !prev_sclk) begin
            chain = {chain[PADS*CB-2:0], sdo};
            edge_cnt++;
            hi_bit = sdo;
         end else if (sclk) begin
            chk("sdo_stable_hi", 32'(sdo), 32'(hi_bit));
         end
         if (mstb) begin
            if (!prev_stb) begin
               stb_len = 0;
               stb_adr = wbm.wbm_adr_o;
            end else begin
               chk("adr_stable", wbm.wbm_adr_o, stb_adr);
            end
            chk("sel_we", {27'b0, wbm.wbm_we_o, wbm.wbm_sel_o}, 32'h0000_000F);
            stb_len++;
         end
         if (!mstb && prev_stb) begin
            if (exp_stb_q.size() == 0) unexpected("stb_len");
            else chk("stb_len", 32'(stb_len), 32'(exp_stb_q.pop_front()));
         end
         if (mstb && wbm.wbm_ack_i) begin
            ack_cnt++;
            if (exp_adr_q.size() == 0) unexpected("read_adr");
            else chk("read_adr", wbm.wbm_adr_o, exp_adr_q.pop_front());
         end
         if (sload) begin
            load_cyc++;
            total_loads++;
         end
         if (sload && !prev_load) begin
            for (int i = 0; i < PADS; i++) begin
               if (exp_pad_q.size() == 0) unexpected("pad_latch");
               else chk($sformatf("pad%0d", i), 32'(chain[CB*i +: CB]), 32'(exp_pad_q.pop_front()));
            end
         end
         if (done) begin
            if (exp_done_q.size() == 0) unexpected("done_rec");
            else chk("done_rec", mk_done(err, load_cyc, edge_cnt, dur_cnt), exp_done_q.pop_front());
            edge_cnt = 0; dur_cnt = 0; load_cyc = 0;
            after_done = 1;
            done_cnt++;
         end
         prev_sclk = sclk;
         prev_load = sload;
         prev_stb  = mstb;
      end
   end

   // Driver tasks: inputs change 2 time units after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
      repeat (2) tick();
   endtask

   task automatic push_xfer(input int lat_i, input logic [12:0] p1, input int dur);
      for (int p = PADS - 1; p >= 0; p--) begin
         exp_adr_q.push_back(BASE + 32'(4 * p));
         exp_stb_q.push_back(16'(lat_i + 1));
      end
      exp_pad_q.push_back(13'h1ABC);
      exp_pad_q.push_back(p1);
      exp_pad_q.push_back(13'h1000);
      exp_pad_q.push_back(13'h0F0F);
      exp_done_q.push_back(mk_done(1'b0, 2, 52, dur));
   endtask

   task automatic check_drained(input string nm);
      chk(nm, 32'(exp_adr_q.size() + exp_stb_q.size() + exp_pad_q.size() + exp_done_q.size()), 32'd0);
   endtask

   task automatic run_xfer(input int lat_i, input logic [12:0] p1, input int dur);
      lat = lat_i;
      push_xfer(lat_i, p1, dur);
      pulse_start();
      wait_done(2000);
      check_drained("queues_drained");
   endtask

   task automatic check_quiet(input string nm);
      chk({nm, "_ctl"}, {22'b0, busy, done, err, wbm.wbm_cyc_o, wbm.wbm_stb_o,
          wbm.wbm_we_o, sclk, sdo, sload, 1'b0}, 32'd0);
      chk({nm, "_sel"}, 32'(wbm.wbm_sel_o), 32'd0);
      chk({nm, "_adr"}, wbm.wbm_adr_o, 32'd0);
      chk({nm, "_state"}, 32'(dbg), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, loads0;
      rst = 1'b1;
      start = 1'b0;
      regs[0] = 32'h0000_1ABC;
      regs[1] = 32'h0000_0001;
      regs[2] = 32'h0000_1000;
      regs[3] = 32'h0000_0F0F;
      repeat (3) tick();
      check_quiet("reset");
      rst = 1'b0;
      tick();

      // 1: basic transfer
      run_xfer(1, 13'h0001, 227);

      // 2: upper register bits are dropped
      regs[1] = 32'hFFFF_E001;
      run_xfer(1, 13'h0001, 227);
      regs[1] = 32'h0000_0001;

      // 3: pad 2 never acks, then a clean retry
      nack_pad = 2;
      exp_adr_q.push_back(BASE + 32'hC);
      exp_stb_q.push_back(16'd2);
      exp_stb_q.push_back(16'd255);
      exp_done_q.push_back(mk_done(1'b1, 0, 13, 312));
      pulse_start();
      wait_done(2000);
      check_drained("timeout_drained");
      chk("err_held", 32'(err), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
      nack_pad = -1;
      run_xfer(1, 13'h0001, 227);
      chk("err_cleared", 32'(err), 32'd0);

      // 4: start during shifting is ignored
      push_xfer(1, 13'h0001, 227);
      pulse_start();
      repeat (20) tick();
      start = 1'b1;
      repeat (10) tick();
      start = 1'b0;
      wait_done(2000);
      repeat (20) tick();
      chk("no_retrigger", 32'(busy), 32'd0);
      check_drained("retrigger_drained");

      // 5: reset while pad 1 is shifting
      a0 = ack_cnt;
      for (int p = 3; p >= 1; p--) begin
         exp_adr_q.push_back(BASE + 32'(4 * p));
         exp_stb_q.push_back(16'd2);
      end
      pulse_start();
      for (int i = 0; i < 500 && ack_cnt != a0 + 3; i++) tick();
      chk("pad1_read_seen", 32'(ack_cnt - a0), 32'd3);
      repeat (10) tick();
      loads0 = total_loads;
      rst = 1'b1;
      tick();
      check_quiet("midrst");
      rst = 1'b0;
      repeat (5) tick();
      chk("midrst_no_load", 32'(total_loads), 32'(loads0));
      chk("midrst_idle", 32'(busy), 32'd0);
      check_drained("midrst_drained");
      run_xfer(1, 13'h0001, 227);

      // 6: slow slave
      run_xfer(5, 13'h0001, 243);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
